// File: rtl/rx8b10b_pkg.sv
// rtl/rx8b10b_pkg.sv - shared 8b/10b receive constants, state type and helpers
package rx8b10b_pkg;

    localparam int COMMA_W = 10;

    // K28.5 in transmit order abcdei_fghj, bit 9 = a
    localparam logic [COMMA_W-1:0] K28_5_NEG = 10'b0011111010;
    localparam logic [COMMA_W-1:0] K28_5_POS = 10'b1100000101;

    // Index of the last bit of a code group in the bit counter
    localparam logic [3:0] LAST_BIT = 4'd9;

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } align_state_t;

    // Saturating increment for the 4-bit alignment counters
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Saturating decrement that stops at zero
    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'h0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/rx_comma_window.sv
// rtl/rx_comma_window.sv - serial shift window, bit phase counter and comma match
module rx_comma_window
    import rx8b10b_pkg::*;
#(
    parameter logic [COMMA_W-1:0] COMMA_NEG = K28_5_NEG,
    parameter logic [COMMA_W-1:0] COMMA_POS = K28_5_POS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               serial_in,
    input  logic               realign,
    output logic [COMMA_W-1:0] win,
    output logic               match,
    output logic               bnd
);

    // Only the nine most recent bits need storing; the tenth is the live input
    logic [COMMA_W-2:0] sr;
    logic [3:0]         bit_cnt;

    assign win   = {sr, serial_in};
    assign match = (win == COMMA_NEG) || (win == COMMA_POS);
    assign bnd   = (bit_cnt == LAST_BIT);

    // Shift in one bit per enabled cycle; restart the word phase on a boundary or realign
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= 4'd0;
        end else if (enb) begin
            sr <= win[COMMA_W-2:0];
            if (realign || bnd) begin
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rx_comma_aligner.sv
// rtl/rx_comma_aligner.sv - K28.5 comma aligner with acquire/sync/loss tracking
module rx_comma_aligner
    import rx8b10b_pkg::*;
#(
    parameter logic [COMMA_W-1:0] COMMA_NEG = K28_5_NEG,
    parameter logic [COMMA_W-1:0] COMMA_POS = K28_5_POS,
    parameter int                 N_COMMA   = 3,
    parameter int                 ERR_MAX   = 4,
    parameter int                 GOOD_RUN  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               serial_in,
    input  logic               code_err,
    output logic [COMMA_W-1:0] data10_out,
    output logic               word_valid,
    output logic               sync,
    output logic               comma_det
);

    localparam logic [3:0] N_COMMA_C  = 4'(N_COMMA);
    localparam logic [3:0] ERR_MAX_C  = 4'(ERR_MAX);
    localparam logic [3:0] GOOD_RUN_C = 4'(GOOD_RUN);

    align_state_t       state, state_nxt;
    logic [3:0]         comma_cnt, comma_cnt_nxt;
    logic [3:0]         err_cnt, err_cnt_nxt;
    logic [3:0]         good_cnt, good_cnt_nxt;
    logic [COMMA_W-1:0] win;
    logic               match;
    logic               bnd;
    logic               realign;
    logic               err_evt;

    rx_comma_window #(
        .COMMA_NEG (COMMA_NEG),
        .COMMA_POS (COMMA_POS)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .serial_in (serial_in),
        .realign   (realign),
        .win       (win),
        .match     (match),
        .bnd       (bnd)
    );

    // Next-state and counter update; realign only happens while not in sync
    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        err_cnt_nxt   = err_cnt;
        good_cnt_nxt  = good_cnt;
        realign       = 1'b0;
        err_evt       = 1'b0;

        case (state)
            ST_LOS: begin
                if (match) begin
                    realign       = 1'b1;
                    comma_cnt_nxt = 4'd1;
                    if (comma_cnt_nxt >= N_COMMA_C) begin
                        state_nxt    = ST_SYNC;
                        err_cnt_nxt  = 4'd0;
                        good_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt = ST_ACQ;
                    end
                end
            end

            ST_ACQ: begin
                if (code_err) begin
                    state_nxt     = ST_LOS;
                    comma_cnt_nxt = 4'd0;
                end else if (match && !bnd) begin
                    realign       = 1'b1;
                    comma_cnt_nxt = 4'd1;
                    if (comma_cnt_nxt >= N_COMMA_C) begin
                        state_nxt    = ST_SYNC;
                        err_cnt_nxt  = 4'd0;
                        good_cnt_nxt = 4'd0;
                    end
                end else if (match && bnd) begin
                    comma_cnt_nxt = sat_inc(comma_cnt);
                    if (comma_cnt_nxt >= N_COMMA_C) begin
                        state_nxt    = ST_SYNC;
                        err_cnt_nxt  = 4'd0;
                        good_cnt_nxt = 4'd0;
                    end
                end
            end

            ST_SYNC: begin
                // A decoder error and a misplaced comma in the same cycle count once
                err_evt = code_err || (match && !bnd);
                if (err_evt) begin
                    err_cnt_nxt  = sat_inc(err_cnt);
                    good_cnt_nxt = 4'd0;
                    if (err_cnt_nxt >= ERR_MAX_C) begin
                        state_nxt     = ST_LOS;
                        comma_cnt_nxt = 4'd0;
                        err_cnt_nxt   = 4'd0;
                        good_cnt_nxt  = 4'd0;
                    end
                end else if (bnd) begin
                    good_cnt_nxt = sat_inc(good_cnt);
                    if (good_cnt_nxt >= GOOD_RUN_C) begin
                        good_cnt_nxt = 4'd0;
                        err_cnt_nxt  = sat_dec(err_cnt);
                    end
                end
            end

            default: begin
                state_nxt     = ST_LOS;
                comma_cnt_nxt = 4'd0;
                err_cnt_nxt   = 4'd0;
                good_cnt_nxt  = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs; enb low freezes everything but the strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOS;
            comma_cnt  <= 4'd0;
            err_cnt    <= 4'd0;
            good_cnt   <= 4'd0;
            data10_out <= '0;
            word_valid <= 1'b0;
            sync       <= 1'b0;
            comma_det  <= 1'b0;
        end else if (!enb) begin
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
        end else begin
            state      <= state_nxt;
            comma_cnt  <= comma_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            good_cnt   <= good_cnt_nxt;
            comma_det  <= match;
            sync       <= (state == ST_SYNC);
            if (bnd || realign) begin
                data10_out <= win;
            end
            word_valid <= realign || (bnd && (state != ST_LOS));
        end
    end

endmodule

// File: tb/tb_rx_comma_aligner.sv
// tb/tb_rx_comma_aligner.sv - scoreboard bench for the comma aligner
module tb_rx_comma_aligner;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       serial_in;
    logic       code_err;
    logic [9:0] data10_out;
    logic       word_valid;
    logic       sync;
    logic       comma_det;

    int n_tests    = 0;
    int n_fail     = 0;
    int comma_seen = 0;

    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    localparam logic [9:0] KN  = 10'b0011111010;
    localparam logic [9:0] KP  = 10'b1100000101;
    localparam logic [9:0] D0  = 10'b1001110100;
    localparam logic [9:0] NOE = 10'b0000000000;

    always #5 clk = ~clk;

    rx_comma_aligner dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .serial_in  (serial_in),
        .code_err   (code_err),
        .data10_out (data10_out),
        .word_valid (word_valid),
        .sync       (sync),
        .comma_det  (comma_det)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop the scoreboard whenever a word is presented
    always @(negedge clk) begin
        if (comma_det === 1'b1) comma_seen++;
        if (word_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %b expected no word at %0t", data10_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", int'(data10_out), int'(mon_exp));
                if (mon_exp == KN || mon_exp == KP)
                    check("comma_det_with_word", int'(comma_det), 1);
            end
        end
    end

    task automatic send_bit(input logic b, input logic e);
        @(negedge clk);
        enb       = 1'b1;
        serial_in = b;
        code_err  = e;
    endtask

    // emask[i] raises code_err while the i-th transmitted bit is sampled
    task automatic send_word(input logic [9:0] w, input bit push, input logic [9:0] emask,
                             input int pause_before);
        if (push) exp_q.push_back(w);
        for (int i = 0; i < 10; i++) begin
            if (i == pause_before) begin
                repeat (5) begin
                    @(negedge clk);
                    enb       = 1'b0;
                    serial_in = 1'($urandom_range(0, 1));
                    code_err  = 1'b0;
                end
            end
            send_bit(w[9-i], emask[i]);
        end
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enb       = 1'b1;
        serial_in = 1'b0;
        code_err  = 1'b0;

        // Reset with random line data
        repeat (2) begin
            @(negedge clk);
            serial_in = 1'($urandom_range(0, 1));
        end
        check("rst_data", int'(data10_out), 0);
        check("rst_valid", int'(word_valid), 0);
        check("rst_sync", int'(sync), 0);
        check("rst_comma_det", int'(comma_det), 0);
        @(negedge clk);
        rst       = 1'b0;
        serial_in = 1'b0;

        // Acquisition at offset 3
        send_idle(3);
        send_word(KN, 1, NOE, -1);
        send_word(KN, 1, NOE, -1);
        send_word(KN, 1, NOE, -1);
        exp_q.push_back(D0);
        send_bit(D0[9], 1'b0);
        check("acq_sync_not_yet", int'(sync), 0);
        send_bit(D0[8], 1'b0);
        check("acq_sync_rise", int'(sync), 1);
        for (int i = 2; i < 10; i++) send_bit(D0[9-i], 1'b0);
        send_word(D0, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        check("acq_sync_hold", int'(sync), 1);
        check("acq_comma_count", comma_seen, 3);

        // Loss of sync: four decoder errors inside three words
        send_word(D0, 1, 10'b0000100100, -1);
        send_word(D0, 1, 10'b0000000100, -1);
        check("los_sync_before", int'(sync), 1);
        send_word(D0, 0, 10'b0000000100, -1);
        check("los_sync_low", int'(sync), 0);
        send_word(D0, 0, NOE, -1);
        send_word(D0, 0, NOE, -1);
        check("los_sync_stays_low", int'(sync), 0);

        // False alignment: comma at offset 3, then at offset 7
        send_idle(3);
        send_word(KN, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        exp_q.push_back(10'b0000000001);
        send_idle(7);
        send_word(KN, 1, NOE, -1);
        send_word(KN, 1, NOE, -1);
        check("false_align_no_sync", int'(sync), 0);
        send_word(KN, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        check("false_align_sync", int'(sync), 1);
        check("false_align_comma_count", comma_seen, 7);

        // Error recovery: 3 errors, good run decrements, one more error tolerated
        send_word(D0, 1, 10'b0000101010, -1);
        send_word(D0, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        send_word(D0, 1, 10'b0000000100, -1);
        check("recover_sync_kept", int'(sync), 1);
        send_word(D0, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        send_word(D0, 1, NOE, -1);
        // Misaligned comma in sync: counted as an error, words stay on the old grid
        exp_q.push_back(10'b0000000111);
        exp_q.push_back(10'b1101000000);
        send_idle(5);
        send_word(KN, 0, NOE, -1);
        send_idle(5);
        check("misaligned_comma_sync_kept", int'(sync), 1);
        send_word(D0, 0, 10'b0000000100, -1);
        check("misaligned_comma_counted", int'(sync), 0);
        check("recover_comma_count", comma_seen, 8);

        // Re-acquire, then enb pause mid-word
        send_word(KN, 1, NOE, -1);
        send_word(KN, 1, NOE, -1);
        send_word(KN, 1, NOE, -1);
        send_word(D0, 1, NOE, 5);
        send_word(D0, 1, NOE, -1);
        check("enb_pause_sync", int'(sync), 1);
        check("enb_pause_comma_count", comma_seen, 11);

        // Reset mid-word while in sync
        for (int i = 0; i < 4; i++) send_bit(D0[9-i], 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        code_err = 1'b0;
        @(negedge clk);
        check("midrst_sync", int'(sync), 0);
        check("midrst_valid", int'(word_valid), 0);
        check("midrst_data", int'(data10_out), 0);
        rst = 1'b0;
        send_word(D0, 0, NOE, -1);
        send_word(D0, 0, NOE, -1);
        check("post_rst_sync", int'(sync), 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("total_comma_count", comma_seen, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_comma_aligner.md
Name: rx_comma_aligner

Overview:
- Receive-side companion to the 8b/10b encoder/serializer path.
- Accepts a serial 8b/10b bit stream, one bit per clock.
- Finds K28.5 comma boundaries and runs an acquire/sync/loss state machine.
- Emits aligned 10-bit code groups to decoder10to8; uses the decoder's code-error flag to detect loss of sync.

Parameters:
- COMMA_NEG, 10'b0011111010, K28.5 RD- in bit order abcdei_fghj (a = bit 9).
- COMMA_POS, 10'b1100000101, K28.5 RD+ in the same bit order.
- N_COMMA, 3, aligned commas required to go from ACQ to SYNC (range 1..7).
- ERR_MAX, 4, error count that forces SYNC to LOS (range 1..7).
- GOOD_RUN, 4, consecutive good words that decrement the error count (range 1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enb  input  1  bit-enable; when low, all state holds.
- serial_in  input  1  received line bit; the first transmitted bit (a) arrives first.
- code_err  input  1  one-cycle pulse from decoder10to8 marking an invalid code group.
- data10_out  output  10  aligned code group; bit 9 = a, bit 0 = j.
- word_valid  output  1  one-cycle strobe; data10_out is valid.
- sync  output  1  high while in state SYNC.
- comma_det  output  1  one-cycle strobe; the window matched a comma this cycle, at any phase.

Behaviour:
- Reset values (rst=1 at posedge, priority over enb):
  - shift register = 0; bit_cnt = 0; state = LOS.
  - comma_cnt = err_cnt = good_cnt = 0.
  - data10_out = 0; word_valid = 0; sync = 0; comma_det = 0.
- enb = 0: every register holds; word_valid and comma_det are forced to 0.
- Shift and window (enb = 1):
  - win = {sr[8:0], serial_in}; sr <= win.
  - match = (win == COMMA_NEG) or (win == COMMA_POS).
  - comma_det <= match, registered, 1-cycle latency.
- Word boundary:
  - bnd = (bit_cnt == 9); bit_cnt wraps 9 -> 0.
  - At a boundary: data10_out <= win; word_valid <= 1 when state != LOS.
  - Latency is 1 clock after the 10th bit is sampled.
- Realign (LOS or ACQ only):
  - Triggered by match with bnd = 0.
  - Current cycle is treated as a boundary: bit_cnt <= 0, data10_out <= win, word_valid <= 1.
- State LOS:
  - word_valid stays 0 except on a realign.
  - match at any phase -> realign, comma_cnt <= 1, go to ACQ.
- State ACQ:
  - bnd & match -> comma_cnt + 1; if the result reaches N_COMMA -> SYNC, err_cnt <= 0, good_cnt <= 0.
  - match off-boundary -> realign, comma_cnt <= 1, stay in ACQ.
  - code_err (any cycle) -> LOS, comma_cnt <= 0.
  - Non-comma word at a boundary -> stay in ACQ.
- State SYNC:
  - Never realigns.
  - err_evt = code_err OR (match & !bnd); simultaneous sources count once.
  - On err_evt: err_cnt + 1, good_cnt <= 0. If the result reaches ERR_MAX -> LOS, all counters cleared, sync falls the next cycle.
  - On a boundary without err_evt: good_cnt + 1. When it reaches GOOD_RUN: good_cnt <= 0 and err_cnt decrements (saturates at 0).
- Counters saturate and never wrap.
- sync is registered from state: high the cycle after entering SYNC, low the cycle after leaving.
- Reset mid-word discards the partial word; alignment is lost.

Decomposition:
- Shared package rx8b10b_pkg holds:
  - state enum LOS / ACQ / SYNC (2 bits);
  - K28_5_NEG and K28_5_POS constants, which are also used by the encoder bench;
  - COMMA_W = 10.
- Natural sub-module rx_comma_window: shift register, bit_cnt, match/bnd generation.
- The parent holds the state machine and the counters.

Test Plan:
- Reset: rst high for 2 cycles, any serial_in -> all outputs 0, sync = 0, word_valid never pulses.
- Acquisition at offset 3: send 3 idle bits, then K28.5 RD- x3 followed by D0.0 words.
  - First comma -> comma_det and word_valid together, data10_out = 0011111010.
  - sync rises 1 cycle after the 3rd comma boundary (bit 33 + 1).
  - D0.0 words then appear on 10-bit strides.
- False alignment: one comma at offset 3, then one comma at offset 7 -> realign, comma_cnt restarts at 1; sync only after 3 commas at offset 7.
- Loss of sync: in SYNC, pulse code_err 4 times within 3 good words -> sync low after the 4th; word_valid stops until the next comma.
- Error recovery: in SYNC, 3 code_err pulses, then 4 good words (err_cnt = 2), then 1 code_err -> sync stays 1; misaligned comma in SYNC increments the error count without realigning.
- enb low for 5 cycles mid-word, then resume -> word boundary and data unchanged; rst asserted mid-SYNC -> LOS next cycle, sync = 0.
